// File: rtl/db15_joy_tx_if.sv
// db15_joy_tx_if: DB15 joystick serial link between the host reader and the adapter
interface db15_joy_tx_if;
  logic joy_clk;
  logic joy_load;
  logic joy_data;
  modport master (output joy_clk, output joy_load, input joy_data);
  modport slave (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/db15_joy_tx.sv
// db15_joy_tx: adapter-side shift chain answering DB15 joystick load/clock from the host
module db15_joy_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER = 2,
  parameter int PLAYER_BITS = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PLAYER_BITS-1:0] joy1_in,
  input  logic [PLAYER_BITS-1:0] joy2_in,
  db15_joy_tx_if.slave           link,
  output logic                   frame_done,
  output logic [4:0]             bit_cnt,
  output logic                   overrun
);
  localparam int N = 2 * PLAYER_BITS;
  localparam int FW = $clog2(FILTER + 1);
  // idle levels: load released (1), shift clock low (0), so release from reset sees no edge
  localparam logic [1:0] RST_LVL = 2'b10;
  logic [1:0] raw, filt;
  logic clk_d, clk_rise, load, armed;
  logic [N-1:0] shreg;
  assign raw = {link.joy_load, link.joy_clk};
  for (genvar g = 0; g < 2; g++) begin : cond
    logic [SYNC_STAGES-1:0] sync;
    logic [FW-1:0] cnt;
    logic lvl;
    // synchronise, then move the filtered level only after FILTER consecutive differing samples
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        sync <= {SYNC_STAGES{RST_LVL[g]}};
        cnt  <= '0;
        lvl  <= RST_LVL[g];
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], raw[g]};
        if (sync[SYNC_STAGES-1] == lvl) cnt <= '0;
        else if (cnt == FW'(FILTER - 1)) begin
          cnt <= '0;
          lvl <= sync[SYNC_STAGES-1];
        end else cnt <= cnt + 1'b1;
      end
    assign filt[g] = lvl;
  end
  assign clk_rise = filt[0] & ~clk_d;
  assign load = ~filt[1];
  // previous filtered shift clock for rising-edge detection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) clk_d <= 1'b0;
    else clk_d <= filt[0];
  // transparent parallel load wins; otherwise shift one bit per host edge once a load has armed the frame
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      shreg      <= '1;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      armed      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        shreg   <= ~{joy2_in, joy1_in};
        bit_cnt <= '0;
        overrun <= 1'b0;
        armed   <= 1'b1;
      end else if (clk_rise && armed) begin
        shreg <= {1'b1, shreg[N-1:1]};
        if (bit_cnt == 5'(N)) overrun <= 1'b1;
        else begin
          bit_cnt    <= bit_cnt + 1'b1;
          frame_done <= (bit_cnt == 5'(N - 1));
        end
      end
    end
  assign link.joy_data = shreg[0];
endmodule

// File: tb/tb_db15_joy_tx.sv
// tb_db15_joy_tx: vector table, model-checked random frames and corner sequences for db15_joy_tx
module tb_db15_joy_tx;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [11:0] joy1_in = '0;
  logic [11:0] joy2_in = '0;
  logic frame_done, overrun;
  logic [4:0] bit_cnt;
  int errors = 0, checks = 0, fd_cnt = 0;
  logic [23:0] m_bits = '1;
  int m_sh = 0;
  bit m_armed = 0;

  typedef struct {
    logic [11:0] j1, j2;
    int n;
    logic d;
    int cnt;
    logic ovr;
    int fd;
  } vec_t;
  vec_t tbl[8];

  db15_joy_tx_if link();
  db15_joy_tx dut (
    .clk(clk), .reset_n(reset_n), .joy1_in(joy1_in), .joy2_in(joy2_in),
    .link(link.slave), .frame_done(frame_done), .bit_cnt(bit_cnt), .overrun(overrun)
  );

  always #10 clk = ~clk;
  always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // model: the frame is the inverted latched words read out LSB first, then idle 1s
  task automatic chk_model(string nm);
    chk({nm, "_data"}, 32'(link.joy_data), (m_armed && m_sh < 24) ? 32'(m_bits[m_sh]) : 32'd1);
    chk({nm, "_cnt"}, 32'(bit_cnt), m_armed ? (m_sh > 24 ? 32'd24 : 32'(m_sh)) : 32'd0);
    chk({nm, "_ovr"}, 32'(overrun), 32'(m_sh > 24));
  endtask

  task automatic do_load(logic [11:0] a, logic [11:0] b);
    joy1_in = a;
    joy2_in = b;
    link.joy_load = 1'b0;
    tick(8);
    m_bits = ~{b, a};
    m_sh = 0;
    m_armed = 1;
    link.joy_load = 1'b1;
    tick(8);
  endtask

  task automatic pulse(int h);
    link.joy_clk = 1'b1;
    tick(h);
    link.joy_clk = 1'b0;
    tick(8);
    if (h >= 2 && m_armed && link.joy_load) m_sh++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fd0;
    logic [11:0] a, b;
    tbl[0] = '{12'h001, 12'h800, 0, 1'b0, 0, 1'b0, 0};
    tbl[1] = '{12'h001, 12'h800, 1, 1'b1, 1, 1'b0, 0};
    tbl[2] = '{12'h001, 12'h800, 23, 1'b0, 23, 1'b0, 0};
    tbl[3] = '{12'h001, 12'h800, 24, 1'b1, 24, 1'b0, 1};
    tbl[4] = '{12'h001, 12'h800, 25, 1'b1, 24, 1'b1, 1};
    tbl[5] = '{12'h000, 12'h000, 12, 1'b1, 12, 1'b0, 0};
    tbl[6] = '{12'hFFF, 12'h000, 11, 1'b0, 11, 1'b0, 0};
    tbl[7] = '{12'h0A5, 12'h5A0, 5, 1'b0, 5, 1'b0, 0};
    link.joy_clk = 1'b0;
    link.joy_load = 1'b1;
    tick(3);
    chk("rst_data", 32'(link.joy_data), 1);
    chk("rst_cnt", 32'(bit_cnt), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_fd", 32'(frame_done), 0);
    reset_n = 1'b1;
    tick(3);

    for (int i = 0; i < 8; i++) begin
      do_load(tbl[i].j1, tbl[i].j2);
      fd0 = fd_cnt;
      for (int k = 0; k < tbl[i].n; k++) pulse(3);
      chk($sformatf("vec%0d_data", i), 32'(link.joy_data), 32'(tbl[i].d));
      chk($sformatf("vec%0d_cnt", i), 32'(bit_cnt), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(tbl[i].ovr));
      chk($sformatf("vec%0d_fd", i), 32'(fd_cnt - fd0), 32'(tbl[i].fd));
    end

    for (int r = 0; r < 6; r++) begin
      a = 12'($urandom);
      b = 12'($urandom);
      do_load(a, b);
      fd0 = fd_cnt;
      chk_model($sformatf("rnd%0d_e0", r));
      for (int e = 1; e <= 26; e++) begin
        pulse(3);
        chk_model($sformatf("rnd%0d_e%0d", r, e));
      end
      chk($sformatf("rnd%0d_fd", r), 32'(fd_cnt - fd0), 1);
    end

    joy1_in = 12'h000;
    joy2_in = 12'h000;
    link.joy_load = 1'b0;
    tick(8);
    m_sh = 0;
    fd0 = fd_cnt;
    for (int k = 0; k < 3; k++) pulse(3);
    chk("ldlow_cnt", 32'(bit_cnt), 0);
    chk("ldlow_fd", 32'(fd_cnt - fd0), 0);
    chk("ldlow_data0", 32'(link.joy_data), 1);
    joy1_in = 12'h001;
    tick(1);
    chk("ldlow_transp", 32'(link.joy_data), 0);
    link.joy_load = 1'b1;
    tick(8);
    m_bits = ~{12'h000, 12'h001};
    m_armed = 1;

    do_load(12'h3C5, 12'hA5A);
    pulse(3);
    pulse(1);
    chk_model("glitch_1clk");
    pulse(3);
    chk_model("pulse_3clk");

    do_load(12'h5A5, 12'h0F0);
    for (int k = 0; k < 10; k++) pulse(3);
    chk_model("pre_rst");
    reset_n = 1'b0;
    #2;
    m_armed = 0;
    m_sh = 0;
    chk("async_rst_data", 32'(link.joy_data), 1);
    chk("async_rst_cnt", 32'(bit_cnt), 0);
    tick(2);
    reset_n = 1'b1;
    tick(4);
    fd0 = fd_cnt;
    for (int k = 0; k < 3; k++) pulse(3);
    chk_model("post_rst");
    chk("post_rst_fd", 32'(fd_cnt - fd0), 0);

    a = 12'($urandom);
    b = 12'($urandom);
    do_load(a, b);
    for (int k = 1; k <= 4; k++) begin
      pulse(3);
      chk_model($sformatf("mid_e%0d", k));
    end
    joy1_in = ~a;
    joy2_in = ~b;
    for (int k = 5; k <= 24; k++) begin
      pulse(3);
      chk_model($sformatf("mid_e%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/db15_joy_tx.md
Name: db15_joy_tx

Overview:
- Device-side responder for the DB15 UserIO joystick serial link.
- Emulates the adapter's cascaded parallel-in/serial-out shift chain: latches two 12-bit player words on JOY_LOAD and shifts them out on JOY_DATA at each JOY_CLK rising edge.
- Serves as the bench model for the host-side DB15 reader and as the firmware-free adapter core for bridge builds.
- Runs in the 40-50 MHz CLK_JOY domain; JOY_CLK and JOY_LOAD arrive asynchronously and are oversampled.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on joy_clk and joy_load (min 2).
- FILTER, 2: consecutive identical synchronised samples required before the filtered level changes (min 1).
- PLAYER_BITS, 12: bits per player word. Frame length is 2*PLAYER_BITS.

Ports:
- clk, input, 1: CLK_JOY, 40-50 MHz.
- reset_n, input, 1: asynchronous, active-low reset.
- joy1_in, input, PLAYER_BITS: player 1 buttons, active-high. Bit order is L S F E D C B A U D L R, bit 0 = R.
- joy2_in, input, PLAYER_BITS: player 2, same bit order.
- joy_clk, input, 1: host shift clock, async; rising edge shifts.
- joy_load, input, 1: host load, async, active-low; low = parallel load.
- joy_data, output, 1: serial data, active-low (0 = pressed).
- frame_done, output, 1: one-cycle pulse when the last frame bit has been shifted past.
- bit_cnt, output, 5: shifts since the last load, saturates at 2*PLAYER_BITS.
- overrun, output, 1: sticky; set by any shift edge after the frame is exhausted.

Behaviour:
- Reset (async assert, sync release):
  - shift register all 1s, joy_data=1, bit_cnt=0, frame_done=0, overrun=0.
  - Synchroniser and filter state for joy_load reset to 1; for joy_clk reset to 0, so no spurious edge is seen after release.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops, then a counter filter.
  - The filtered level updates only after FILTER consecutive equal samples that differ from the current filtered level.
  - clk_rise = filtered joy_clk goes 0 to 1.
- Load (filtered joy_load = 0), evaluated every clk:
  - shreg <= ~{joy2_in, joy1_in}; bit_cnt <= 0; overrun <= 0.
  - Load is transparent: input changes during load appear on joy_data within 1 clk.
  - clk_rise while load is low is ignored. Load takes priority over a simultaneous shift.
- Shift (filtered joy_load = 1 and clk_rise):
  - shreg <= {1'b1, shreg[N-1:1]}, i.e. a 1 is fed in at the top.
  - If bit_cnt < N: bit_cnt increments. When the new value equals N, frame_done pulses for exactly 1 clk.
  - If bit_cnt == N already: overrun <= 1, bit_cnt holds, no frame_done.
- Output:
  - joy_data = shreg[0], registered.
  - Serial order: joy1[0..11], then joy2[0..11], then 1s forever.
  - Latency from a raw joy_clk edge to the joy_data update is SYNC_STAGES+FILTER+1 clk (5 at defaults, 125 ns at 40 MHz). The host must sample no earlier than this after its edge.
- Inputs joy1_in/joy2_in are sampled only during load. Changes mid-frame do not alter the bits in flight.
- Reset mid-frame: abort immediately to the reset values. The next frame requires a fresh load.
- Pulses on joy_clk or joy_load shorter than FILTER clk are rejected: no shift and no load.

Test Plan:
- Reset, then load with joy1_in=12'h001, joy2_in=12'h800, then 24 clean JOY_CLK pulses:
  - joy_data before the first edge is 0.
  - The next 22 bits are 1.
  - Bit 23 (joy2[11]) is 0.
  - frame_done pulses once after edge 24; bit_cnt=24.
- Same frame plus a 25th edge:
  - joy_data stays 1 and overrun=1.
  - The next load clears overrun and bit_cnt.
- JOY_CLK pulses while JOY_LOAD is low:
  - bit_cnt stays 0, no frame_done.
  - Changing joy1_in from 0 to 12'h001 drives joy_data from 1 to 0 within 1 clk.
- 1-clk glitch on joy_clk with FILTER=2:
  - no shift, bit_cnt unchanged.
  - A 3-clk pulse shifts exactly once.
- Assert reset_n=0 after 10 shifts:
  - joy_data=1, bit_cnt=0 asynchronously.
  - After release, no shift occurs until a new load.
- Change joy1_in mid-frame after 4 shifts:
  - the remaining bits match the values latched at load, not the new inputs.
